// File: rtl/lut_neuron_pipe.sv
// Pipelined LUT neuron: RAM-held truth table, cleared after reset and reloadable
// through a streaming config port; lookups flow through a valid/ready pipeline.
module lut_neuron_pipe #(
   parameter int IN_BITS     = 8,
   parameter int OUT_BITS    = 2,
   parameter int PIPE_STAGES = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_BITS-1:0]  in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OUT_BITS-1:0] out_data,
   input  logic                cfg_start,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [OUT_BITS-1:0] cfg_data,
   output logic                cfg_done,
   output logic                busy
);
   localparam int DEPTH = 1 << IN_BITS;

   typedef enum logic [1:0] {CLEAR, RUN, DRAIN, LOAD} state_t;

   state_t                              state, state_nxt;
   logic [IN_BITS:0]                    addr, addr_nxt;
   logic [OUT_BITS-1:0]                 mem [DEPTH];
   logic [PIPE_STAGES:1]                vld_pipe;
   logic [PIPE_STAGES:1][OUT_BITS-1:0]  dat_pipe;
   logic [OUT_BITS-1:0]                 rd_data, wdata;
   logic                                stall, accept, last, we;

   assign out_valid = vld_pipe[PIPE_STAGES];
   assign out_data  = dat_pipe[PIPE_STAGES];
   assign stall     = out_valid & ~out_ready;
   assign accept    = in_valid & in_ready;
   assign rd_data   = mem[in_data];
   assign last      = (addr == (IN_BITS+1)'(DEPTH-1));
   assign busy      = (state != RUN);

   // Table storage has no reset; CLEAR zeroes it instead.
   always_ff @(posedge clk)
      if (we) mem[addr[IN_BITS-1:0]] <= wdata;

   // Whole pipeline freezes on stall; data regs only load on valid so
   // out_data keeps the last result when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         dat_pipe <= '0;
      end else if (!stall) begin
         vld_pipe[1] <= accept;
         if (accept) dat_pipe[1] <= rd_data;
         for (int s = 2; s <= PIPE_STAGES; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLEAR;
         addr  <= '0;
      end else begin
         state <= state_nxt;
         addr  <= addr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      we        = 1'b0;
      wdata     = cfg_data;
      in_ready  = 1'b0;
      cfg_ready = 1'b0;
      cfg_done  = 1'b0;
      case (state)
         CLEAR: begin
            we       = 1'b1;
            wdata    = '0;
            addr_nxt = addr + 1'b1;
            if (last) begin
               state_nxt = RUN;
               addr_nxt  = '0;
            end
         end
         RUN: begin
            in_ready = ~stall;
            if (cfg_start) begin
               // A lookup accepted this cycle must still flush through DRAIN
               state_nxt = (|vld_pipe || (in_valid && !stall)) ? DRAIN : LOAD;
               addr_nxt  = '0;
            end
         end
         DRAIN: begin
            if (!(|vld_pipe)) begin
               state_nxt = LOAD;
               addr_nxt  = '0;
            end
         end
         LOAD: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               we       = 1'b1;
               addr_nxt = addr + 1'b1;
               if (last) begin
                  cfg_done  = 1'b1;
                  state_nxt = RUN;
                  addr_nxt  = '0;
               end
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end
endmodule
